// File: rtl/mul_arb_pkg.sv
// Shared defaults and the stage-1 record layout for the round-robin multiplier arbiter.
package mul_arb_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int NREQ_DEF  = 4;
    localparam int ID_W      = $clog2(NREQ_DEF);
    localparam int PROD_W    = 2 * WIDTH_DEF;

    typedef struct packed {
        logic [PROD_W-1:0] psum_hi;
        logic [PROD_W-1:0] psum_lo;
        logic              valid;
        logic [ID_W-1:0]   id;
    } s1_rec_t;

endpackage

// File: rtl/mul_pipe_core.sv
// Two-stage shift-add multiplier: stage 1 forms upper/lower partial sums, stage 2 adds them.
module mul_pipe_core
    import mul_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = ID_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               in_valid,
    input  logic [IDW-1:0]     in_id,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic               out_valid,
    output logic [IDW-1:0]     out_id,
    output logic [2*WIDTH-1:0] out_data
);

    localparam int PW   = 2 * WIDTH;
    localparam int HALF = WIDTH / 2;

    // Same layout as s1_rec_t, sized by this instance's parameters.
    typedef struct packed {
        logic [PW-1:0]  psum_hi;
        logic [PW-1:0]  psum_lo;
        logic           valid;
        logic [IDW-1:0] id;
    } s1_t;

    s1_t            s1_d, s1_q;
    logic [PW-1:0]  row;
    logic           valid_q;
    logic [IDW-1:0] id_q;
    logic [PW-1:0]  data_q;

    always_comb begin
        s1_d = '0;
        row  = '0;
        for (int j = 0; j < WIDTH; j++) begin
            row = in_y[j] ? (PW'(in_x) << j) : '0;
            if (j >= HALF) begin
                s1_d.psum_hi = s1_d.psum_hi + row;
            end else begin
                s1_d.psum_lo = s1_d.psum_lo + row;
            end
        end
        s1_d.valid = in_valid;
        s1_d.id    = in_id;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s1_q    <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
        end else if (en) begin
            s1_q    <= s1_d;
            valid_q <= s1_q.valid;
            id_q    <= s1_q.id;
            data_q  <= s1_q.psum_hi + s1_q.psum_lo;
        end
    end

    assign out_valid = valid_q;
    assign out_id    = id_q;
    assign out_data  = data_q;

endmodule

// File: rtl/mul_arb_rr.sv
// Round-robin arbiter feeding a shared two-stage multiplier.
// Define MUL_ARB_STATS_EN to add saturating issue_cnt/stall_cnt outputs.
module mul_arb_rr
    import mul_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_x,
    input  logic [NREQ*WIDTH-1:0]    req_y,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [2*WIDTH-1:0]       rsp_data
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [15:0]              issue_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_idx;
    logic             grant_any;
    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] op_x, op_y;
    int               idx;

    assign stall = rsp_valid & ~rsp_ready;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // clr gating keeps req_ready low during reset even with requests pending.
    assign accept    = clr & ~stall & grant_any;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign op_x = req_x[grant_idx*WIDTH +: WIDTH];
    assign op_y = req_y[grant_idx*WIDTH +: WIDTH];

    mul_pipe_core #(
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) u_core (
        .clk       (clk),
        .clr       (clr),
        .en        (~stall),
        .in_valid  (accept),
        .in_id     (grant_idx),
        .in_x      (op_x),
        .in_y      (op_y),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_data  (rsp_data)
    );

`ifdef MUL_ARB_STATS_EN
    logic [15:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept && issue_cnt_q != 16'hFFFF) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_arb_rr.sv
// Bench for mul_arb_rr: queue-based reference model checked every cycle plus directed literal checks.
module tb_mul_arb_rr;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req_valid;
    logic [15:0] req_x, req_y;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
`ifdef MUL_ARB_STATS_EN
    logic [15:0] issue_cnt, stall_cnt;
    logic [15:0] s0;
`endif

    always #5 clk = ~clk;

    mul_arb_rr #(.NREQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef MUL_ARB_STATS_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight ops in issue order, each with the number of
    // pipeline-advancing edges it has seen; an op is visible once that reaches 2.
    typedef struct {
        int id;
        int prod;
        int age;
    } op_t;

    op_t q[$];
    int  mptr;
    int  m_issue;
    int  m_stall;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit exp_v();
        return (q.size() > 0) && (q[0].age >= 2);
    endfunction

    bit  mv;
    int  mg;
    op_t op;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            q.delete();
            mptr    = 0;
            m_issue = 0;
            m_stall = 0;
        end else begin
            mv = exp_v();
            if (mv && !rsp_ready) begin
                m_stall = m_stall + 1;
            end else begin
                if (mv) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
                mg = pick(req_valid, mptr);
                if (mg >= 0) begin
                    op.id   = mg;
                    op.prod = req_x[mg*4 +: 4] * req_y[mg*4 +: 4];
                    op.age  = 1;
                    q.push_back(op);
                    mptr    = (mg + 1) % 4;
                    m_issue = m_issue + 1;
                end
            end
        end
    end

    bit cev;
    int cg;

    always @(negedge clk) begin
        if (!clr) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_data", rsp_data, 0);
            chk("rst_id", rsp_id, 0);
        end else begin
            cev = exp_v();
            cg  = pick(req_valid, mptr);
            if (cev && !rsp_ready) chk("model_ready", req_ready, 0);
            else chk("model_ready", req_ready, (cg >= 0) ? (1 << cg) : 0);
            chk("model_valid", rsp_valid, cev);
            if (cev) begin
                chk("model_id", rsp_id, q[0].id);
                chk("model_data", rsp_data, q[0].prod);
            end
`ifdef MUL_ARB_STATS_EN
            chk("model_issue_cnt", issue_cnt, m_issue);
            chk("model_stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clr       = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;

        @(posedge clk); #2;
        req_valid = 4'hF;
        #1;
        chk("reset_ready_with_req", req_ready, 0);
        chk("reset_valid", rsp_valid, 0);
        chk("reset_data", rsp_data, 0);
        chk("reset_id", rsp_id, 0);
        @(negedge clk); #2;
        clr       = 1'b1;
        req_valid = '0;

        // Single requester 2, F*F
        req_x[11:8] = 4'hF;
        req_y[11:8] = 4'hF;
        req_valid   = 4'b0100;
        #1 chk("single_ready", req_ready, 4'b0100);
        cyc();
        req_valid = '0;
        #1 chk("single_not_yet", rsp_valid, 0);
        cyc();
        #1;
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 2);
        chk("single_data", rsp_data, 8'hE1);
        cyc();

        // Wrap: only 3, then 0 and 3
        req_valid = 4'b1000;
        #1 chk("wrap_grant3", req_ready, 4'b1000);
        cyc();
        req_valid = 4'b1001;
        #1 chk("wrap_grant0", req_ready, 4'b0001);
        cyc();
        #1 chk("wrap_grant3_again", req_ready, 4'b1000);
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        // All requesters continuously valid
        req_x     = {4'd4, 4'd3, 4'd2, 4'd1};
        req_y     = {4'd7, 4'd6, 4'd5, 4'd4};
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_grant", req_ready, 1 << (i % 4));
            if (i >= 2) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_id", rsp_id, (i - 2) % 4);
            end
            cyc();
        end
        req_valid = '0;
        repeat (3) cyc();

        // Zero operand and identity operand
        req_x[3:0] = 4'h0;
        req_y[3:0] = 4'h9;
        req_valid  = 4'b0001;
        cyc();
        req_x[7:4] = 4'hA;
        req_y[7:4] = 4'h1;
        req_valid  = 4'b0010;
        cyc();
        req_valid = '0;
        #1 chk("zero_data", rsp_data, 8'h00);
        chk("zero_id", rsp_id, 0);
        cyc();
        #1 chk("ident_data", rsp_data, 8'h0A);
        chk("ident_id", rsp_id, 1);
        cyc();
        cyc();

        // Back-pressure for 3 cycles
        req_x[11:8] = 4'h3;
        req_y[11:8] = 4'h5;
        req_valid   = 4'b0100;
        cyc();
        req_valid = '0;
        rsp_ready = 1'b0;
        cyc();
`ifdef MUL_ARB_STATS_EN
        s0 = stall_cnt;
`endif
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", req_ready, 0);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 8'h0F);
            chk("stall_id", rsp_id, 2);
            cyc();
        end
        #1 chk("stall_data_end", rsp_data, 8'h0F);
`ifdef MUL_ARB_STATS_EN
        chk("stall_cnt_delta", stall_cnt - s0, 3);
`endif
        rsp_ready = 1'b1;
        req_valid = '0;
        cyc();
        #1 chk("stall_released", rsp_valid, 0);

        // Reset with two operations in flight
        req_valid = 4'b0011;
        cyc();
        cyc();
        req_valid = '0;
        clr       = 1'b0;
        #1 chk("clr_flush_now", rsp_valid, 0);
        #4 clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1 chk("clr_no_result", rsp_valid, 0);
        end
        req_valid = 4'b1010;
        #1 chk("clr_lowest_grant", req_ready, 4'b0010);
        cyc();
        req_valid = '0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
